vdp_sprite_scan: RTL

VDP_SPRITE_SCAN -- requirements
Module: vdp_sprite_scan

---
 rtl/vdp_sprite_scan.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/vdp_sprite_scan.sv
// Per-scanline sprite evaluator: walks the sprite attribute table in VRAM and
// latches up to NUM_SLOTS sprites that intersect the requested line.
module vdp_sprite_scan #(
    parameter int NUM_SLOTS   = 8,
    parameter int SAT_ENTRIES = 64,
    parameter int ADDR_W      = 14
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             line_start,
    input  logic [7:0]                       line_y,
    input  logic                             tall,
    input  logic                             zoom,
    input  logic [ADDR_W-9:0]                sat_base,
    output logic                             vram_req,
    output logic [ADDR_W-1:0]                vram_addr,
    input  logic                             vram_ack,
    input  logic [7:0]                       vram_data,
    output logic [NUM_SLOTS-1:0]             slot_valid,
    output logic [NUM_SLOTS*8-1:0]           slot_x,
    output logic [NUM_SLOTS*8-1:0]           slot_pat,
    output logic [NUM_SLOTS*4-1:0]           slot_row,
    output logic [$clog2(NUM_SLOTS+1)-1:0]   slot_cnt,
    output logic                             overflow,
    output logic                             busy,
    output logic                             scan_done
);
    localparam int CW = $clog2(NUM_SLOTS + 1);
    localparam int SW = $clog2(NUM_SLOTS);
    localparam int IW = $clog2(SAT_ENTRIES);

    typedef enum logic [2:0] {IDLE, RD_Y, RD_X, RD_N, DONE} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [7:0]          line_y_q, line_y_d;
    logic                tall_q, tall_d, zoom_q, zoom_d;
    logic [ADDR_W-9:0]   base_q, base_d;
    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          x_q [NUM_SLOTS];
    logic [7:0]          x_d [NUM_SLOTS];
    logic [7:0]          pat_q [NUM_SLOTS];
    logic [7:0]          pat_d [NUM_SLOTS];
    logic [3:0]          row_q [NUM_SLOTS];
    logic [3:0]          row_d [NUM_SLOTS];
    logic                req_q, req_d, busy_q, busy_d, done_q, done_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic                ack_s, hit_s, last_s, full_s;
    logic [7:0]          dist_s, height_s;
    logic [3:0]          row_s;
    logic [SW-1:0]       sel_s;

    // Acks only count while a read is outstanding; distance is modulo 256.
    always_comb begin
        ack_s    = vram_ack & req_q;
        dist_s   = line_y_q - vram_data;
        height_s = 8'd8 << ({1'b0, tall_q} + {1'b0, zoom_q});
        hit_s    = dist_s < height_s;
        row_s    = zoom_q ? dist_s[4:1] : dist_s[3:0];
        last_s   = idx_q == IW'(SAT_ENTRIES - 1);
        full_s   = cnt_q == CW'(NUM_SLOTS);
        sel_s    = cnt_q[SW-1:0];
    end

    // Next-state, slot updates and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        line_y_d = line_y_q;
        tall_d   = tall_q;
        zoom_d   = zoom_q;
        base_d   = base_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        x_d      = x_q;
        pat_d    = pat_q;
        row_d    = row_q;
        if (line_start) begin
            line_y_d = line_y;
            tall_d   = tall;
            zoom_d   = zoom;
            base_d   = sat_base;
            valid_d  = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            idx_d    = '0;
            state_d  = RD_Y;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                RD_Y: begin
                    if (!ack_s) begin
                        state_d = RD_Y;
                    end else if (vram_data == 8'hD0) begin
                        state_d = DONE;
                    end else if (hit_s) begin
                        if (full_s) begin
                            ovf_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            row_d[sel_s] = row_s;
                            state_d      = RD_X;
                        end
                    end else if (last_s) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1'b1);
                        state_d = RD_Y;
                    end
                end
                RD_X: begin
                    if (ack_s) begin
                        x_d[sel_s] = vram_data;
                        state_d    = RD_N;
                    end else begin
                        state_d = RD_X;
                    end
                end
                RD_N: begin
                    if (ack_s) begin
                        pat_d[sel_s]   = tall_q ? {vram_data[7:1], 1'b0} : vram_data;
                        valid_d[sel_s] = 1'b1;
                        cnt_d          = cnt_q + CW'(1'b1);
                        if (last_s) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + IW'(1'b1);
                            state_d = RD_Y;
                        end
                    end else begin
                        state_d = RD_N;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        req_d  = (state_d == RD_Y) || (state_d == RD_X) || (state_d == RD_N);
        busy_d = req_d;
        done_d = state_d == DONE;
        case (state_d)
            RD_Y:    addr_d = {base_d, 8'h00} + ADDR_W'(idx_d);
            RD_X:    addr_d = {base_d, 8'h80} + ADDR_W'({idx_d, 1'b0});
            RD_N:    addr_d = {base_d, 8'h80} + ADDR_W'({idx_d, 1'b0}) + ADDR_W'(1'b1);
            default: addr_d = '0;
        endcase
    end

    // State and output registers; reset overrides everything including line_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            line_y_q <= 8'h00;
            tall_q   <= 1'b0;
            zoom_q   <= 1'b0;
            base_q   <= '0;
            valid_q  <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i]   <= 8'h00;
                pat_q[i] <= 8'h00;
                row_q[i] <= 4'h0;
            end
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            line_y_q <= line_y_d;
            tall_q   <= tall_d;
            zoom_q   <= zoom_d;
            base_q   <= base_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            x_q      <= x_d;
            pat_q    <= pat_d;
            row_q    <= row_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            addr_q   <= addr_d;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
        assign slot_x[g*8 +: 8]   = x_q[g];
        assign slot_pat[g*8 +: 8] = pat_q[g];
        assign slot_row[g*4 +: 4] = row_q[g];
    end

    assign slot_valid = valid_q;
    assign slot_cnt   = cnt_q;
    assign overflow   = ovf_q;
    assign vram_req   = req_q;
    assign vram_addr  = addr_q;
    assign busy       = busy_q;
    assign scan_done  = done_q;
endmodule
